// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access pipeline stage sitting between the EX/MEM and MEM/WB
// registers. Word loads and stores are issued on a simple req/ack bus.
// While an access is outstanding the upstream pipeline is frozen through
// out_Stall. A small three-state controller sequences each access:
//
//   IDLE -> WAIT : aligned memory op seen (request latched, stall asserted)
//   WAIT -> DONE : ack received, or no ack after TIMEOUT wait cycles
//   DONE -> IDLE : always, so the instruction still held in EX/MEM during
//                  DONE can never start a second access
//
// Parameters
//   TIMEOUT        maximum WAIT cycles before the access is abandoned (2..65535)
//
// Ports
//   clk            pipeline clock, rising edge
//   rst_n          asynchronous active-low reset
//   in_Valid       EX/MEM holds a live instruction
//   in_MemRead     load
//   in_MemWrite    store (wins when both MemRead and MemWrite are high)
//   in_Branch      branch control
//   in_Zero        ALU zero flag
//   in_ALU         effective address
//   in_WriteData   store data
//   mem_rdata      memory read data, valid with mem_ack
//   mem_ack        memory completion strobe (ignored outside WAIT)
//   mem_req        access request (high for every WAIT cycle)
//   mem_we         1 = write
//   mem_addr       word address, low two bits always zero
//   mem_wdata      store data
//   out_ReadData   load result to MEM/WB
//   out_ANDGate    branch taken
//   out_Stall      freeze PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB
//   out_AddrError  misaligned access attempted this cycle
//   out_BusError   one-cycle pulse after a timed-out access
//   out_StallCount saturating count of stall cycles
// ---------------------------------------------------------------------------
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_Valid,
  input  logic        in_MemRead,
  input  logic        in_MemWrite,
  input  logic        in_Branch,
  input  logic        in_Zero,
  input  logic [31:0] in_ALU,
  input  logic [31:0] in_WriteData,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] out_ReadData,
  output logic        out_ANDGate,
  output logic        out_Stall,
  output logic        out_AddrError,
  output logic        out_BusError,
  output logic [15:0] out_StallCount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Value of the wait counter on the last WAIT cycle allowed before abandoning.
  localparam logic [15:0] LP_WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  logic [15:0] r_wait_cnt;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_bus_err;
  logic [15:0] r_stall_cnt;

  logic w_mem_op;
  logic w_aligned;
  logic w_start;
  logic w_misaligned;
  logic w_wait_last;
  logic w_stall;

  // -------------------------------------------------------------------------
  // Combinational decode
  // -------------------------------------------------------------------------
  assign w_mem_op     = in_Valid & (in_MemRead | in_MemWrite);
  assign w_aligned    = (in_ALU[1:0] == 2'b00);
  assign w_start      = (r_state == S_IDLE) & w_mem_op & w_aligned;
  assign w_misaligned = (r_state == S_IDLE) & w_mem_op & ~w_aligned;
  assign w_wait_last  = (r_wait_cnt == LP_WAIT_LAST);

  // The stall has to be raised in the very cycle the access is recognised,
  // otherwise EX/MEM would advance before the request is even issued.
  assign w_stall = w_start | (r_state == S_WAIT);

  // -------------------------------------------------------------------------
  // Access controller
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 16'd0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_bus_err  <= 1'b0;
    end else begin
      // Bus error is a single-cycle pulse; only the timeout branch re-arms it.
      r_bus_err <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state    <= S_WAIT;
            r_req      <= 1'b1;
            // Both MemRead and MemWrite high is treated as a store.
            r_we       <= in_MemWrite;
            r_addr     <= {in_ALU[31:2], 2'b00};
            r_wdata    <= in_WriteData;
            r_wait_cnt <= 16'd0;
          end else if (w_misaligned) begin
            // A rejected access must not leave stale load data behind.
            r_rdata <= 32'd0;
          end
        end

        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 16'd1;
          // Ack is tested first so an ack on the final allowed cycle wins
          // over the timeout.
          if (mem_ack) begin
            if (!r_we) begin
              r_rdata <= mem_rdata;
            end
            r_req   <= 1'b0;
            r_state <= S_DONE;
          end else if (w_wait_last) begin
            r_bus_err <= 1'b1;
            r_rdata   <= 32'd0;
            r_req     <= 1'b0;
            r_state   <= S_DONE;
          end
        end

        S_DONE: begin
          // EX/MEM advances at the end of this cycle; returning to IDLE
          // without looking at the inputs keeps the still-visible
          // instruction from triggering a second access.
          r_wait_cnt <= 16'd0;
          r_state    <= S_IDLE;
        end

        default: begin
          r_wait_cnt <= 16'd0;
          r_req      <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Saturating stall-cycle counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'd0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign mem_req        = r_req;
  assign mem_we         = r_we;
  assign mem_addr       = r_addr;
  assign mem_wdata      = r_wdata;
  assign out_ReadData   = r_rdata;
  assign out_BusError   = r_bus_err;
  assign out_StallCount = r_stall_cnt;
  assign out_Stall      = w_stall;
  assign out_AddrError  = w_misaligned;
  assign out_ANDGate    = in_Valid & in_Branch & in_Zero;

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
//
// Drives whole instructions into the memory-access stage and predicts, per
// instruction, the cycle-by-cycle outputs from the stage's rules: an aligned
// memory op stalls for one cycle plus one per wait cycle, the wait ends on
// ack or after TIMEOUT cycles, and a DONE cycle follows. A single compare
// process checks every cycle against those predictions; a few literal values
// from the directed scenarios are checked as well.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_Valid, in_MemRead, in_MemWrite, in_Branch, in_Zero;
  logic [31:0] in_ALU, in_WriteData, mem_rdata;
  logic        mem_ack;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, out_ReadData;
  logic        out_ANDGate, out_Stall, out_AddrError, out_BusError;
  logic [15:0] out_StallCount;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_Valid      (in_Valid),
    .in_MemRead    (in_MemRead),
    .in_MemWrite   (in_MemWrite),
    .in_Branch     (in_Branch),
    .in_Zero       (in_Zero),
    .in_ALU        (in_ALU),
    .in_WriteData  (in_WriteData),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .out_ReadData  (out_ReadData),
    .out_ANDGate   (out_ANDGate),
    .out_Stall     (out_Stall),
    .out_AddrError (out_AddrError),
    .out_BusError  (out_BusError),
    .out_StallCount(out_StallCount)
  );

  int errors = 0;
  int checks = 0;

  // Expected outputs for the current cycle.
  logic        chk_en = 1'b0;
  logic        e_stall, e_req, e_addrerr, e_buserr, e_bus_chk, e_we;
  logic [31:0] e_rdata, e_addr, e_wdata;
  logic [15:0] e_cnt;
  logic        pin_en = 1'b0;
  logic [31:0] pin_rd;
  logic [15:0] pin_cnt;

  // Architectural model state.
  int          m_cnt;
  logic [31:0] m_rdata;
  int          txn = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Single compare process, sampling mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst_n) begin
        chk("rst_req",   32'(mem_req), 32'd0);
        chk("rst_we",    32'(mem_we), 32'd0);
        chk("rst_addr",  mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", out_ReadData, 32'd0);
        chk("rst_buserr", 32'(out_BusError), 32'd0);
        chk("rst_cnt",   32'(out_StallCount), 32'd0);
      end else begin
        chk("stall",   32'(out_Stall), 32'(e_stall));
        chk("req",     32'(mem_req), 32'(e_req));
        chk("addrerr", 32'(out_AddrError), 32'(e_addrerr));
        chk("buserr",  32'(out_BusError), 32'(e_buserr));
        chk("rdata",   out_ReadData, e_rdata);
        chk("cnt",     32'(out_StallCount), 32'(e_cnt));
        chk("andgate", 32'(out_ANDGate), 32'(in_Valid & in_Branch & in_Zero));
        if (e_bus_chk) begin
          chk("we",    32'(mem_we), 32'(e_we));
          chk("addr",  mem_addr, e_addr);
          chk("wdata", mem_wdata, e_wdata);
        end
        if (pin_en) begin
          chk("pin_rdata", out_ReadData, pin_rd);
          chk("pin_cnt",   32'(out_StallCount), 32'(pin_cnt));
        end
      end
    end
  end

  function automatic int sat_inc(input int c);
    return (c >= 65535) ? 65535 : c + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    pin_en = 1'b0;
  endtask

  task automatic set_exp(input logic stall, input logic req, input logic aerr,
                         input logic berr, input logic bchk);
    e_stall   = stall;
    e_req     = req;
    e_addrerr = aerr;
    e_buserr  = berr;
    e_bus_chk = bchk;
    e_rdata   = m_rdata;
    e_cnt     = m_cnt[15:0];
  endtask

  // One cycle with no access start (either not valid, or valid with no op).
  task automatic plain_cycle(input logic v, input logic b, input logic z,
                             input logic rd, input logic wr);
    in_Valid     = v;
    in_MemRead   = v ? 1'b0 : rd;
    in_MemWrite  = v ? 1'b0 : wr;
    in_Branch    = b;
    in_Zero      = z;
    in_ALU       = $urandom;
    in_WriteData = $urandom;
    mem_ack      = 1'($urandom);
    mem_rdata    = $urandom;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic misaligned(input logic rd, input logic wr, input logic [31:0] addr);
    logic [31:0] a;
    a = addr;
    if (a[1:0] == 2'b00) a[0] = 1'b1;
    in_Valid = 1'b1; in_MemRead = rd; in_MemWrite = wr;
    in_Branch = 1'($urandom); in_Zero = 1'($urandom);
    in_ALU = a; in_WriteData = $urandom;
    mem_ack = 1'($urandom); mem_rdata = $urandom;
    set_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    m_rdata = 32'd0;
    txn++;
    $display("txn %0d misaligned addr=%h rdata->0", txn, a);
  endtask

  // Full aligned access. lat = WAIT cycle carrying the ack (lat > TO: none).
  // rst_at > 0 pulses reset in that WAIT cycle and abandons the access.
  task automatic mem_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int lat, input int rst_at, input logic pin,
                        input logic [31:0] prd, input logic [15:0] pcnt);
    logic st;
    logic tout;
    int   w;
    st   = wr;
    tout = (lat > TO);
    w    = tout ? TO : lat;

    // IDLE cycle: access recognised, stall raised at once.
    in_Valid = 1'b1; in_MemRead = rd; in_MemWrite = wr;
    in_ALU = addr; in_WriteData = wdata;
    in_Branch = 1'($urandom); in_Zero = 1'($urandom);
    mem_ack = 1'($urandom); mem_rdata = $urandom;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    m_cnt = sat_inc(m_cnt);

    for (int k = 1; k <= w; k++) begin
      in_ALU = $urandom; in_WriteData = $urandom;
      in_Branch = 1'($urandom); in_Zero = 1'($urandom);
      mem_ack   = (k == lat);
      mem_rdata = (k == lat) ? rdata : $urandom;
      set_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      e_we = st; e_addr = addr; e_wdata = wdata;
      if (k == rst_at) begin
        #1 rst_n = 1'b0;
        in_Valid = 1'b0; in_MemRead = 1'b0; in_MemWrite = 1'b0; mem_ack = 1'b0;
        tick();
        m_cnt   = 0;
        m_rdata = 32'd0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        tick();
        txn++;
        $display("txn %0d reset during wait %0d addr=%h", txn, k, addr);
        return;
      end
      tick();
      m_cnt = sat_inc(m_cnt);
    end

    if (tout)     m_rdata = 32'd0;
    else if (!st) m_rdata = rdata;

    // DONE cycle: instruction still presented, must not retrigger.
    in_ALU = addr; in_WriteData = wdata;
    mem_ack = 1'($urandom); mem_rdata = $urandom;
    set_exp(1'b0, 1'b0, 1'b0, tout, 1'b0);
    pin_en = pin; pin_rd = prd; pin_cnt = pcnt;
    tick();
    txn++;
    $display("txn %0d %s addr=%h waits=%0d timeout=%0d rdata=%h stalls=%0d",
             txn, st ? "store" : "load", addr, w, tout, m_rdata, m_cnt);
  endtask

  initial begin
    logic [31:0] a;
    logic        rd, wr;
    int          kind;

    rst_n = 1'b0;
    in_Valid = 1'b0; in_MemRead = 1'b0; in_MemWrite = 1'b0;
    in_Branch = 1'b0; in_Zero = 1'b0;
    in_ALU = 32'd0; in_WriteData = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
    m_cnt = 0; m_rdata = 32'd0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_we = 1'b0; e_addr = 32'd0; e_wdata = 32'd0;
    pin_rd = 32'd0; pin_cnt = 16'd0;

    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    tick();
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    tick();

    // Directed scenarios.
    mem_op(1'b1, 1'b0, 32'h0000_0010, 32'd0, 32'hCAFE_F00D, 1, 0, 1'b1, 32'hCAFE_F00D, 16'd2);
    mem_op(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hDEAD_0000, 3, 0, 1'b1, 32'hCAFE_F00D, 16'd6);
    mem_op(1'b1, 1'b0, 32'h0000_0030, 32'd0, 32'h1111_2222, 99, 0, 1'b1, 32'd0, 16'd11);
    mem_op(1'b1, 1'b0, 32'h0000_0040, 32'd0, 32'hA5A5_0001, 4, 0, 1'b1, 32'hA5A5_0001, 16'd16);
    misaligned(1'b1, 1'b0, 32'h0000_0013);
    plain_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    plain_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    mem_op(1'b1, 1'b0, 32'h0000_0044, 32'd0, 32'd0, 99, 2, 1'b0, 32'd0, 16'd0);
    mem_op(1'b1, 1'b0, 32'h0000_0050, 32'd0, 32'h0BAD_BEEF, 2, 0, 1'b1, 32'h0BAD_BEEF, 16'd3);

    // Randomized mix, including back-to-back accesses.
    for (int n = 0; n < 250; n++) begin
      kind = int'($urandom_range(0, 7));
      a  = $urandom;
      rd = 1'($urandom);
      wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      if (kind <= 4) begin
        a[1:0] = 2'b00;
        mem_op(rd, wr, a, $urandom, $urandom, int'($urandom_range(1, TO + 2)),
               0, 1'b0, 32'd0, 16'd0);
      end else if (kind == 5) begin
        misaligned(rd, wr, a);
      end else begin
        plain_cycle(1'($urandom), 1'($urandom), 1'($urandom), rd, wr);
        txn++;
        $display("txn %0d plain cycle", txn);
      end
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
